// File: rtl/router_pkg.sv
// Shared router definitions: byte width, header field layout and the control
// FSM state encoding used by both the FSM and the datapath register stage.
package router_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_BITS  = 2;

    // Header layout: [ADDR_BITS-1:0] destination, [DATA_WIDTH-1:ADDR_BITS] length
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = ADDR_BITS - 1;
    localparam int LEN_LSB  = ADDR_BITS;
    localparam int LEN_MSB  = DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS     = 3'd0,
        ST_LOAD_FIRST_DATA    = 3'd1,
        ST_LOAD_DATA          = 3'd2,
        ST_LOAD_PARITY        = 3'd3,
        ST_FIFO_FULL_STATE    = 3'd4,
        ST_LOAD_AFTER_FULL    = 3'd5,
        ST_WAIT_TILL_EMPTY    = 3'd6,
        ST_CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    function automatic logic [ADDR_BITS-1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_pkt_reg_if.sv
// Bundle between the router control FSM / input port (master) and the
// datapath register stage (slave).
interface router_pkt_reg_if #(parameter int DATA_WIDTH = router_pkg::DATA_WIDTH);

    // pkt_valid marks data_in as a header/payload byte (low = parity byte);
    // fifo_full stalls acceptance: a byte is taken only when !fifo_full,
    // otherwise it is parked and re-issued in the load-after-full state.
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pkt_valid;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic [DATA_WIDTH-1:0] dout;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic                  err;

    modport master (
        output data_in, pkt_valid, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  data_in, pkt_valid, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity, captured trailing parity byte and sticky mismatch flag.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] acc_data,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  check_en,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] internal_parity_q, internal_parity_d;
    logic [DATA_WIDTH-1:0] packet_parity_q, packet_parity_d;
    logic                  err_q, err_d;

    always_comb begin
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        err_d             = err_q;
        if (clear) begin
            internal_parity_d = '0;
            packet_parity_d   = '0;
            err_d             = 1'b0;
        end else begin
            if (acc_en)
                internal_parity_d = internal_parity_q ^ acc_data;
            if (load_en)
                packet_parity_d = load_data;
            // Compares registered values, so err settles one cycle after parity_done
            if (check_en)
                err_d = (internal_parity_q != packet_parity_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            err_q             <= 1'b0;
        end else begin
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            err_q             <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register stage: header hold, full-FIFO byte parking,
// output byte register and parity bookkeeping driven by the FSM strobes.
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    router_pkt_reg_if.slave  bus
);

    logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
    logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;

    logic                  ld_parity_take;
    logic                  laf_parity_take;
    logic                  acc_en;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_data;

    // Parity byte accepted directly, or re-issued after it was parked
    assign ld_parity_take  = bus.ld_state && !bus.fifo_full && !bus.pkt_valid;
    assign laf_parity_take = bus.laf_state && low_pkt_valid_q && !parity_done_q;

    always_comb begin
        header_byte_d   = header_byte_q;
        full_byte_d     = full_byte_q;
        dout_d          = dout_q;
        low_pkt_valid_d = low_pkt_valid_q;
        parity_done_d   = parity_done_q;

        if (bus.detect_add && bus.pkt_valid)
            header_byte_d = bus.data_in;

        if (bus.lfd_state)
            dout_d = header_byte_q;
        else if (bus.ld_state && !bus.fifo_full)
            dout_d = bus.data_in;
        else if (bus.ld_state && bus.fifo_full)
            full_byte_d = bus.data_in;
        else if (bus.laf_state)
            dout_d = full_byte_q;

        if (bus.rst_int_reg)
            low_pkt_valid_d = 1'b0;
        else if (bus.ld_state && !bus.pkt_valid)
            low_pkt_valid_d = 1'b1;

        if (bus.detect_add)
            parity_done_d = 1'b0;
        else if (ld_parity_take || laf_parity_take)
            parity_done_d = 1'b1;
    end

    always_comb begin
        acc_en   = 1'b0;
        acc_data = '0;
        if (bus.lfd_state) begin
            acc_en   = 1'b1;
            acc_data = header_byte_q;
        end else if (bus.ld_state && bus.pkt_valid && !bus.full_state && !bus.fifo_full) begin
            acc_en   = 1'b1;
            acc_data = bus.data_in;
        end else if (bus.laf_state && bus.pkt_valid) begin
            acc_en   = 1'b1;
            acc_data = full_byte_q;
        end

        load_en   = ld_parity_take || laf_parity_take;
        load_data = ld_parity_take ? bus.data_in : full_byte_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            header_byte_q   <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_byte_q   <= header_byte_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_acc (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (bus.detect_add),
        .acc_en    (acc_en),
        .acc_data  (acc_data),
        .load_en   (load_en),
        .load_data (load_data),
        .check_en  (parity_done_q),
        .err       (bus.err)
    );

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;

endmodule
